// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divisor helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam logic [7:0] UART_TX_ADDR = 8'h03;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO, extra pointer MSB separates full from empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter, 8N1; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       uart_tx
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             fifo_pop;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             bit_last;
    logic             load;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (we),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (tx_full),
        .empty     (fifo_empty)
    );

    assign bit_last = (cnt_q == CNT_LAST);
    assign uart_tx  = tx_q;
    assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_last ? '0 : cnt_q + CNT_ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        fifo_pop  = 1'b0;
        load      = 1'b0;
        // Line level follows the current state, so uart_tx lags state by one clock.
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                load  = !fifo_empty;
            end
            ST_START: begin
                if (bit_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_last) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_last) begin
                    state_d = ST_IDLE;
                    load    = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            cnt_d    = '0;
            state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo at DIV=8
module tb_uart_tx_fifo;
    localparam int CLK_HZ = 8;
    localparam int BAUD   = 1;
    localparam int DIV    = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx_full;
    logic       tx_busy;
    logic       uart_tx;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .data_in (data_in),
        .tx_full (tx_full),
        .tx_busy (tx_busy),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Starts on the first start-bit sample; ends one sample past the frame.
    task automatic check_frame(input string tag, input logic [7:0] b, input logic end_busy);
        int line_err = 0;
        int busy_err = 0;
        int n = FRAME_BITS * DIV;
        for (int s = 0; s < n; s++) begin
            if (uart_tx !== exp_bit(b, s / DIV)) line_err++;
            if (tx_busy !== ((s == n - 1) ? end_busy : 1'b1)) busy_err++;
            step();
        end
        check({tag, "_line"}, line_err, 0);
        check({tag, "_busy"}, busy_err, 0);
    endtask

    task automatic run_case(input string tag, input int n_push, input logic [7:0] bytes [8],
                            input logic [7:0] full_mask, input int n_frames);
        fork
            begin
                for (int i = 0; i < n_push; i++) begin
                    we = 1'b1;
                    data_in = bytes[i];
                    step();
                    check($sformatf("%s_full%0d", tag, i), tx_full, full_mask[i]);
                end
                we = 1'b0;
            end
            begin
                step();
                step();
                check({tag, "_prestart"}, uart_tx, 1'b1);
                step();
                for (int f = 0; f < n_frames; f++) begin
                    check_frame($sformatf("%s_frame%0d", tag, f), bytes[f], (f == n_frames - 1) ? 1'b0 : 1'b1);
                end
            end
        join
        repeat (4) step();
    endtask

    initial begin
        logic [7:0] v [8];
        int bad;

        rst = 1'b1;
        repeat (2) step();
        check("rst_tx", uart_tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_full", tx_full, 1'b0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        v = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_case("a5", 1, v, 8'b0000_0000, 1);

        v = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_case("b2b", 3, v, 8'b0000_0000, 3);

        v = '{8'h10, 8'h81, 8'h3C, 8'hFF, 8'h55, 8'hEE, 8'h00, 8'h00};
        run_case("fill", 6, v, 8'b0011_0000, 5);

        v = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_case("p07", 1, v, 8'b0000_0000, 1);

        // Reset inside data bit 1 of 8'h3C (line low), with a second byte queued.
        we = 1'b1; data_in = 8'h3C; step();
        data_in = 8'h5A; step();
        we = 1'b0;
        repeat (19) step();
        check("rst_pre_line", uart_tx, 1'b0);
        check("rst_pre_busy", tx_busy, 1'b1);
        rst = 1'b1;
        step();
        check("rst_mid_tx", uart_tx, 1'b1);
        check("rst_mid_busy", tx_busy, 1'b0);
        check("rst_mid_full", tx_full, 1'b0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20 * DIV; i++) begin
            step();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("rst_no_frames", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmit end of the CPU's memory-mapped UART port. The I/O decoder's write strobe for the UART TX data address (8'h03) pushes a byte into a small FIFO. The block serializes queued bytes onto `uart_tx` as 8N1 frames, LSB first, at a fixed baud rate derived from the system clock. Status outputs let the CPU poll for space before writing.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate; `DIV = CLK_HZ / BAUD` (integer division, must be ≥ 2).
- `FIFO_DEPTH`, 4, byte entries; power of two, ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  push strobe, one cycle per byte (from I/O decode of 8'h03).
- `data_in`  in  8  byte to push, sampled when `we`=1.
- `tx_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `tx_busy`  out  1  frame in progress or FIFO non-empty.
- `uart_tx`  out  1  serial line, idle high, registered.

## Operation
- Reset values:
  - `uart_tx`=1, `tx_full`=0, `tx_busy`=0.
  - FIFO empty, pointers 0, FSM in IDLE, baud counter 0, bit index 0.
- Push: when `we`=1 and not full, write `data_in` at the write pointer and advance it.
  - `we`=1 while full: byte dropped, no state change.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full coinciding with a pop: accepted.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide; MSB distinguishes full from empty; wrap is natural.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when configured).
  - IDLE: if FIFO non-empty, pop into the shift register, clear the baud counter, go to START. `uart_tx`=1.
  - START: `uart_tx`=0 for DIV cycles, then DATA with bit index 0.
  - DATA: `uart_tx`=shift[0] for DIV cycles, shift right; after bit index 7, go to STOP.
  - STOP: `uart_tx`=1 for DIV cycles. At the last cycle: if FIFO non-empty, pop and go to START (no idle gap); else go to IDLE.
- Baud counter runs 0..DIV-1 and resets at each bit boundary.
- `tx_busy` = (state ≠ IDLE) | FIFO non-empty.
- Reset asserted mid-frame aborts the frame. `uart_tx` returns to 1 on the next edge; FIFO contents are discarded.

## Timing
- `we` sampled at edge N → FIFO non-empty after N → IDLE pops at edge N+1 → `uart_tx` falls after edge N+2.
- Each bit lasts exactly DIV clocks.
- Frame is 10·DIV clocks (11·DIV with parity).
- Back-to-back queued bytes produce contiguous frames.
- `tx_full` updates the cycle after the push that fills the FIFO, and deasserts the cycle after the pop.
- All outputs are registered or decoded from registers; no combinational path from `we` or `data_in` to any output.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - Drives the even-parity bit (XOR of the 8 data bits) for DIV cycles.
  - Frame becomes 11·DIV.
- Undefined: no PARITY state, 8N1 frame of 10·DIV.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_state_t`.
  - Constant `UART_TX_ADDR = 8'h03`.
  - Function computing DIV from CLK_HZ and BAUD; reused by the future receiver.
- One sub-module: `sync_fifo` (parameterized width/depth, push/pop/full/empty). Instantiated with width 8.
- FSM, baud counter and shift register stay in the top module.

## Test plan
- Reset, then idle 50 cycles → `uart_tx`=1, `tx_busy`=0, `tx_full`=0 throughout.
- CLK_HZ=8, BAUD=1 (DIV=8); push 8'hA5 → start bit low 8 clocks, then bits 1,0,1,0,0,1,0,1, then stop high. Line falls 2 clocks after the push edge; `tx_busy` drops after 80 clocks of frame.
- Push 8'h01, 8'h02, 8'h03 on consecutive cycles → three contiguous frames, no idle between stop and next start, bytes in order.
- DIV=8, FIFO_DEPTH=4; push 6 bytes on consecutive cycles:
  - first byte popped immediately;
  - bytes 2–5 fill the FIFO and `tx_full`=1;
  - 6th dropped;
  - exactly 5 frames transmitted.
- Assert `rst` for 1 cycle mid-DATA of a frame → `uart_tx`=1 next edge, FIFO empty, no further frames.
- With `UART_TX_PARITY_EN`, push 8'h07 → parity bit 1 after data, frame length 88 clocks at DIV=8.
